uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_tx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity modes, FSM states and
// the decoder that maps the 2-bit parity_mode input onto parity_mode_t.
package uart_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // 2'b11 is a second encoding of "no parity".
   function automatic parity_mode_t decode_parity(input logic [1:0] mode);
      case (mode)
         2'b01:   return EVEN;
         2'b10:   return ODD;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 and wraps, so every serial bit
// lasts exactly CLK_DIV cycles. Held at zero while restart_i is high so the
// first bit of a frame starts with a full period.
module uart_baud_tick #(
   parameter int CLK_DIV = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o,
   output logic near_tick_o
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_NEAR = CW'(CLK_DIV - 2);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: restart, wrap at the end of a bit, otherwise increment.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // tick_o marks the last cycle of a bit; near_tick_o the cycle before it,
   // which lets the FSM register a pulse that lands on the last cycle.
   assign tick_o      = (cnt_q == CNT_LAST);
   assign near_tick_o = (cnt_q == CNT_NEAR);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames one DATA_W-bit word as start, data (LSB
// first), optional parity and 1 or 2 stop bits on a registered serial line.
//
// Handshake: a frame is accepted on a rising edge where tx_valid and
// tx_ready are both 1. tx_ready is high only in IDLE, so tx_valid is
// ignored while a frame is in flight and nothing is queued.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              tx_bit,
   output logic              tx_busy,
   output logic              tx_done,
   output logic [2:0]        state_dbg_o
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   tx_state_t         state_q,    state_d;
   logic [IW-1:0]     idx_q,      idx_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic [DATA_W-1:0] data_q,     data_d;
   parity_mode_t      par_q,      par_d;
   logic              stop2_q,    stop2_d;
   logic              tx_bit_q,   tx_bit_d;
   logic              tx_done_q,  tx_done_d;

   logic baud_tick;
   logic baud_near;
   logic par_bit;

   uart_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clock       (clock),
      .reset       (reset),
      .restart_i   (state_q == IDLE),
      .tick_o      (baud_tick),
      .near_tick_o (baud_near)
   );

   // State register and all registered outputs; reset wins over acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         par_q      <= NONE;
         stop2_q    <= 1'b0;
         tx_bit_q   <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         stop_cnt_q <= stop_cnt_d;
         data_q     <= data_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         tx_bit_q   <= tx_bit_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Next-state logic: capture the frame on acceptance, advance on each bit tick.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      stop_cnt_d = stop_cnt_q;
      data_d     = data_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d    = START;
               data_d     = tx_data;
               par_d      = decode_parity(parity_mode);
               stop2_d    = stop2;
               idx_d      = '0;
               stop_cnt_d = 1'b0;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (idx_q == IDX_LAST) begin
                  state_d    = (par_q == NONE) ? STOP : PARITY;
                  stop_cnt_d = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         PARITY: begin
            if (baud_tick) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == stop2_q) begin
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: line level for the upcoming cycle, and tx_done one cycle
   // ahead so the registered pulse sits on the final cycle of the last stop bit.
   always_comb begin
      par_bit  = (^data_q) ^ (par_q == ODD);
      tx_bit_d = 1'b1;
      case (state_d)
         START:   tx_bit_d = 1'b0;
         DATA:    tx_bit_d = data_q[idx_d];
         PARITY:  tx_bit_d = par_bit;
         default: tx_bit_d = 1'b1;
      endcase
      tx_done_d = (state_q == STOP) && (stop_cnt_q == stop2_q) && baud_near;
   end

   assign tx_bit      = tx_bit_q;
   assign tx_done     = tx_done_q;
   assign tx_ready    = (state_q == IDLE);
   assign tx_busy     = (state_q != IDLE);
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: an 8-bit/CLK_DIV=4 instance and a
// 5-bit/CLK_DIV=2 instance, checked cycle by cycle against hand-written frames.
module tb_uart_tx_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;

   logic       a_valid, a_ready, a_stop2, a_bit, a_busy, a_done;
   logic [7:0] a_data;
   logic [1:0] a_pmode;
   logic [2:0] a_state;

   logic       b_valid, b_ready, b_stop2, b_bit, b_busy, b_done;
   logic [4:0] b_data;
   logic [1:0] b_pmode;
   logic [2:0] b_state;

   int checks   = 0;
   int failures = 0;

   uart_tx_engine #(.DATA_W(8), .CLK_DIV(4)) dut_a (
      .clock       (clk),
      .reset       (reset),
      .tx_valid    (a_valid),
      .tx_ready    (a_ready),
      .tx_data     (a_data),
      .parity_mode (a_pmode),
      .stop2       (a_stop2),
      .tx_bit      (a_bit),
      .tx_busy     (a_busy),
      .tx_done     (a_done),
      .state_dbg_o (a_state)
   );

   uart_tx_engine #(.DATA_W(5), .CLK_DIV(2)) dut_b (
      .clock       (clk),
      .reset       (reset),
      .tx_valid    (b_valid),
      .tx_ready    (b_ready),
      .tx_data     (b_data),
      .parity_mode (b_pmode),
      .stop2       (b_stop2),
      .tx_bit      (b_bit),
      .tx_busy     (b_busy),
      .tx_done     (b_done),
      .state_dbg_o (b_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input bit sel, input string tag);
      check({tag, "_bit"},   32'(sel ? b_bit   : a_bit),   32'd1);
      check({tag, "_ready"}, 32'(sel ? b_ready : a_ready), 32'd1);
      check({tag, "_busy"},  32'(sel ? b_busy  : a_busy),  32'd0);
      check({tag, "_done"},  32'(sel ? b_done  : a_done),  32'd0);
   endtask

   // Called at the negedge of frame cycle 1; returns at the negedge of the
   // first cycle after the frame. exp_bits[0] is the start bit.
   task automatic check_frame(input bit sel, input string tag, input int nbits,
                              input logic [15:0] exp_bits, input int cdiv, input bit toggle);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < cdiv; c++) begin
            check($sformatf("%s_b%0d_c%0d_bit", tag, b, c),
                  32'(sel ? b_bit : a_bit), 32'(exp_bits[b]));
            check($sformatf("%s_b%0d_c%0d_done", tag, b, c),
                  32'(sel ? b_done : a_done), 32'((b == nbits - 1) && (c == cdiv - 1)));
            check($sformatf("%s_b%0d_c%0d_busy", tag, b, c),
                  32'(sel ? b_busy : a_busy), 32'd1);
            check($sformatf("%s_b%0d_c%0d_ready", tag, b, c),
                  32'(sel ? b_ready : a_ready), 32'd0);
            if (toggle) begin
               a_data  = ~a_data;
               a_pmode = a_pmode + 2'd1;
               a_stop2 = ~a_stop2;
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0; a_data = '0; a_pmode = 2'b00; a_stop2 = 1'b0;
      b_valid = 1'b0; b_data = '0; b_pmode = 2'b00; b_stop2 = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_idle(1'b0, "rst_a");
      check_idle(1'b1, "rst_b");
      check("rst_a_state", 32'(a_state), 32'd0);
      check("rst_b_state", 32'(b_state), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_idle(1'b0, "post_rst_a");

      // 0xA5, even parity, one stop: 0,1,0,1,0,0,1,0,1,0,1
      a_data = 8'hA5; a_pmode = 2'b01; a_stop2 = 1'b0; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      check_frame(1'b0, "t1", 11, 16'h054A, 4, 1'b0);
      check_idle(1'b0, "t1_end");

      // 0x01, odd parity (bit 0), two stops: 48 cycles
      a_data = 8'h01; a_pmode = 2'b10; a_stop2 = 1'b1; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      check_frame(1'b0, "t2", 12, 16'h0C02, 4, 1'b0);
      check_idle(1'b0, "t2_end");

      // 0xFF, parity none (encoded 11), tx_valid held across three frames
      a_data = 8'hFF; a_pmode = 2'b11; a_stop2 = 1'b0; a_valid = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         check_frame(1'b0, $sformatf("t3_f%0d", f), 10, 16'h03FE, 4, 1'b0);
         check_idle(1'b0, $sformatf("t3_gap%0d", f));
         if (f < 2) begin
            @(negedge clk);
         end else begin
            a_valid = 1'b0;
         end
      end
      @(negedge clk);

      // Reset at frame cycle 17 (data bit 3 of 0xA5 = 0), tx_valid high with it
      a_data = 8'hA5; a_pmode = 2'b00; a_stop2 = 1'b0; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (16) @(negedge clk);
      check("t4_c17_bit",  32'(a_bit),  32'd0);
      check("t4_c17_busy", 32'(a_busy), 32'd1);
      reset = 1'b1; a_valid = 1'b1;
      @(negedge clk);
      check_idle(1'b0, "t4_after_rst");
      @(negedge clk);
      check_idle(1'b0, "t4_rst_prio");
      check("t4_rst_prio_state", 32'(a_state), 32'd0);
      reset = 1'b0; a_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check($sformatf("t4_quiet%0d_done", i), 32'(a_done), 32'd0);
         check($sformatf("t4_quiet%0d_bit", i),  32'(a_bit),  32'd1);
      end

      // 0x3C even, one stop, with data/parity/stop2 toggled every cycle
      a_data = 8'h3C; a_pmode = 2'b01; a_stop2 = 1'b0; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      check_frame(1'b0, "t5", 11, 16'h0478, 4, 1'b1);
      check_idle(1'b0, "t5_end");

      // DATA_W=5, CLK_DIV=2: 0x15 even (parity 1), two stops: 9 bits, 18 cycles
      b_data = 5'h15; b_pmode = 2'b01; b_stop2 = 1'b1; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      check_frame(1'b1, "t6", 9, 16'h01EA, 2, 1'b0);
      check_idle(1'b1, "t6_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
